// File: rtl/job_dispatcher.sv
// Job dispatcher: splits a nonce range across hashing cores and
// funnels golden nonces from all cores into one FIFO for the transmitter.
module job_dispatcher #(
    parameter int NUM_CORES  = 4,
    parameter int LOG2_CORES = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [255:0]            job_midstate,
    input  logic [95:0]             job_data,
    input  logic [31:0]             job_nonce_min,
    input  logic [31:0]             job_nonce_max,
    output logic [NUM_CORES-1:0]    core_start,
    output logic [255:0]            core_midstate,
    output logic [95:0]             core_data,
    output logic [32*NUM_CORES-1:0] core_nonce_start,
    output logic [32*NUM_CORES-1:0] core_nonce_end,
    input  logic [NUM_CORES-1:0]    core_done,
    input  logic [NUM_CORES-1:0]    core_found,
    input  logic [32*NUM_CORES-1:0] core_nonce,
    output logic                    nonce_valid,
    input  logic                    nonce_ready,
    output logic [31:0]             nonce_out,
    output logic                    busy,
    output logic                    exhausted,
    output logic [7:0]              dropped_count
);

    localparam int PW = (LOG2_CORES > 0) ? LOG2_CORES : 1;
    localparam int FW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [255:0]            r_job_mid;
    logic [95:0]             r_job_data;
    logic [31:0]             r_min;
    logic [31:0]             r_max;
    logic [255:0]            r_mid;
    logic [95:0]             r_data;
    logic [NUM_CORES-1:0]    r_start;
    logic [NUM_CORES-1:0]    r_started;
    logic [NUM_CORES-1:0]    r_done;
    logic [NUM_CORES-1:0]    r_pending;
    logic [32*NUM_CORES-1:0] r_ns;
    logic [32*NUM_CORES-1:0] r_ne;
    logic [31:0]             r_pnonce [NUM_CORES];
    logic [PW-1:0]           r_rr;
    logic [31:0]             r_fifo [FIFO_DEPTH];
    logic [FW-1:0]           r_wr;
    logic [FW-1:0]           r_rd;
    logic [FW:0]             r_cnt;
    logic [7:0]              r_dropped;

    logic                    w_accept;
    logic                    w_run;
    logic                    w_all_done;
    logic [32:0]             w_span;
    logic [32:0]             w_chunk;
    logic                    w_empty;
    logic [32*NUM_CORES-1:0] w_ns;
    logic [32*NUM_CORES-1:0] w_ne;
    logic [NUM_CORES-1:0]    w_mask;
    logic [NUM_CORES-1:0]    w_found;
    logic [NUM_CORES-1:0]    w_set;
    logic [NUM_CORES-1:0]    w_drop;
    logic [NUM_CORES-1:0]    w_done_in;
    logic [NUM_CORES-1:0]    w_gnt_oh;
    logic [NUM_CORES-1:0]    w_clr;
    logic                    w_gnt_vld;
    logic [PW-1:0]           w_gnt_idx;
    logic [PW-1:0]           w_idx;
    logic [PW-1:0]           w_rr_nxt;
    logic                    w_full;
    logic                    w_push;
    logic                    w_pop;
    logic [4:0]              w_ndrop;
    logic [8:0]              w_drop_sum;

    assign w_run      = (r_state == S_RUN);
    assign job_ready  = (r_state != S_LOAD);
    assign w_accept   = job_valid & job_ready;
    assign w_all_done = &(r_done | ~r_started);

    assign w_found   = core_found & {NUM_CORES{w_run & ~w_accept}};
    assign w_drop    = w_found & r_pending;
    assign w_set     = w_found & ~r_pending;
    assign w_done_in = core_done & r_started & {NUM_CORES{w_run}};

    assign w_full = (r_cnt == (FW+1)'(FIFO_DEPTH));
    assign w_pop  = nonce_valid & nonce_ready;
    // A full FIFO still takes a new entry when its head leaves this cycle
    assign w_push = w_gnt_vld & (~w_full | w_pop);
    assign w_clr  = w_push ? w_gnt_oh : '0;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_LOAD;
            S_LOAD: w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_accept)
                    w_state_nxt = S_LOAD;
                else if (w_all_done)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // An empty job passes through RUN with nothing started, so it retires
    // on the same path as a normal job
    assign w_span  = {1'b0, r_max} - {1'b0, r_min} + 33'd1;
    assign w_chunk = w_span >> LOG2_CORES;
    assign w_empty = (r_min > r_max);

    always_comb begin
        w_ns   = '0;
        w_ne   = '0;
        w_mask = '0;
        if (!w_empty) begin
            if (w_chunk == '0) begin
                w_ns[31:0] = r_min;
                w_ne[31:0] = r_max;
                w_mask[0]  = 1'b1;
            end else begin
                w_mask = '1;
                for (int i = 0; i < NUM_CORES; i++) begin
                    w_ns[32*i +: 32] = r_min + w_chunk[31:0] * 32'(i);
                    if (i == NUM_CORES - 1)
                        w_ne[32*i +: 32] = r_max;
                    else
                        w_ne[32*i +: 32] = r_min
                            + w_chunk[31:0] * 32'(i + 1) - 32'd1;
                end
            end
        end
    end

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_idx     = '0;
        w_gnt_oh  = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            w_idx = PW'((int'(r_rr) + k) % NUM_CORES);
            if (!w_gnt_vld && r_pending[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
        w_gnt_oh[w_gnt_idx] = w_gnt_vld;
        w_rr_nxt = PW'((int'(w_gnt_idx) + 1) % NUM_CORES);
    end

    always_comb begin
        w_ndrop = '0;
        for (int i = 0; i < NUM_CORES; i++)
            w_ndrop = w_ndrop + 5'(w_drop[i]);
        w_drop_sum = {1'b0, r_dropped} + 9'(w_ndrop);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state    <= S_IDLE;
            r_job_mid  <= '0;
            r_job_data <= '0;
            r_min      <= '0;
            r_max      <= '0;
            r_mid      <= '0;
            r_data     <= '0;
            r_start    <= '0;
            r_started  <= '0;
            r_done     <= '0;
            r_pending  <= '0;
            r_ns       <= '0;
            r_ne       <= '0;
            r_rr       <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_cnt      <= '0;
            r_dropped  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_dropped <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
            r_start   <= '0;
            if (w_accept) begin
                r_job_mid  <= job_midstate;
                r_job_data <= job_data;
                r_min      <= job_nonce_min;
                r_max      <= job_nonce_max;
                r_pending  <= '0;
                r_done     <= '0;
                r_wr       <= '0;
                r_rd       <= '0;
                r_cnt      <= '0;
            end else begin
                r_pending <= (r_pending & ~w_clr) | w_set;
                r_done    <= r_done | w_done_in;
                if (w_push) begin
                    r_wr <= r_wr + 1'b1;
                    r_rr <= w_rr_nxt;
                end
                if (w_pop)
                    r_rd <= r_rd + 1'b1;
                if (w_push && !w_pop)
                    r_cnt <= r_cnt + 1'b1;
                else if (!w_push && w_pop)
                    r_cnt <= r_cnt - 1'b1;
            end
            if (r_state == S_LOAD) begin
                r_start   <= w_mask;
                r_started <= w_mask;
                r_ns      <= w_ns;
                r_ne      <= w_ne;
                r_mid     <= r_job_mid;
                r_data    <= r_job_data;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push && !w_accept)
            r_fifo[r_wr] <= r_pnonce[w_gnt_idx];
        for (int i = 0; i < NUM_CORES; i++)
            if (w_set[i])
                r_pnonce[i] <= core_nonce[32*i +: 32];
    end

    assign core_start       = r_start;
    assign core_midstate    = r_mid;
    assign core_data        = r_data;
    assign core_nonce_start = r_ns;
    assign core_nonce_end   = r_ne;
    assign nonce_valid      = (r_cnt != '0);
    assign nonce_out        = nonce_valid ? r_fifo[r_rd] : 32'h0;
    assign busy             = (r_state != S_IDLE);
    assign exhausted        = w_run & w_all_done & ~w_accept;
    assign dropped_count    = r_dropped;

endmodule

// File: tb/tb_job_dispatcher.sv
// Directed bench for job_dispatcher: range split, retire timing,
// round-robin nonce collection with drops, and job preemption.
module tb_job_dispatcher;

    localparam int N = 4;

    logic           CLK = 1'b0;
    logic           RST_N;
    logic           job_valid;
    logic           job_ready;
    logic [255:0]   job_midstate;
    logic [95:0]    job_data;
    logic [31:0]    job_nonce_min;
    logic [31:0]    job_nonce_max;
    logic [N-1:0]   core_start;
    logic [255:0]   core_midstate;
    logic [95:0]    core_data;
    logic [32*N-1:0] core_nonce_start;
    logic [32*N-1:0] core_nonce_end;
    logic [N-1:0]   core_done;
    logic [N-1:0]   core_found;
    logic [32*N-1:0] core_nonce;
    logic           nonce_valid;
    logic           nonce_ready;
    logic [31:0]    nonce_out;
    logic           busy;
    logic           exhausted;
    logic [7:0]     dropped_count;

    int n_vec  = 0;
    int n_err  = 0;
    int n_pops = 0;
    logic [31:0] sb[$];

    always #5 CLK = ~CLK;

    job_dispatcher #(
        .NUM_CORES(N), .LOG2_CORES(2), .FIFO_DEPTH(4)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_midstate(job_midstate), .job_data(job_data),
        .job_nonce_min(job_nonce_min), .job_nonce_max(job_nonce_max),
        .core_start(core_start), .core_midstate(core_midstate),
        .core_data(core_data), .core_nonce_start(core_nonce_start),
        .core_nonce_end(core_nonce_end), .core_done(core_done),
        .core_found(core_found), .core_nonce(core_nonce),
        .nonce_valid(nonce_valid), .nonce_ready(nonce_ready),
        .nonce_out(nonce_out), .busy(busy), .exhausted(exhausted),
        .dropped_count(dropped_count)
    );

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop on every handshake, then advance one clock
    task automatic step();
        logic [31:0] e;
        if (nonce_valid && nonce_ready) begin
            if (sb.size() != 0) e = sb.pop_front();
            else e = 'x;
            n_pops++;
            chk("nonce_pop", nonce_out, e);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic push_job(input logic [31:0] mn, input logic [31:0] mx);
        chk("job_ready_offer", job_ready, 1'b1);
        job_valid     = 1'b1;
        job_nonce_min = mn;
        job_nonce_max = mx;
        job_midstate  = {8{mn ^ 32'hA5A55A5A}};
        job_data      = {3{mx ^ 32'h3C3CC3C3}};
        step();
        job_valid = 1'b0;
    endtask

    task automatic done_pulse(input logic [N-1:0] d);
        core_done = d;
        step();
        core_done = '0;
    endtask

    initial begin
        RST_N = 1'b0;
        job_valid = 1'b0;
        job_midstate = '0;
        job_data = '0;
        job_nonce_min = '0;
        job_nonce_max = '0;
        core_done = '0;
        core_found = '0;
        core_nonce = '0;
        nonce_ready = 1'b0;
        step();
        step();
        RST_N = 1'b1;
        chk("rst_job_ready", job_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_core_start", core_start, '0);
        chk("rst_nonce_valid", nonce_valid, 1'b0);
        chk("rst_nonce_out", nonce_out, '0);
        chk("rst_exhausted", exhausted, 1'b0);
        chk("rst_dropped", dropped_count, '0);
        chk("rst_range_start", core_nonce_start, '0);
        chk("rst_range_end", core_nonce_end, '0);
        chk("rst_midstate", core_midstate, '0);
        chk("rst_data", core_data, '0);
        repeat (3) step();
        chk("idle_busy", busy, 1'b0);

        // Full 2^32 range
        push_job(32'h0, 32'hFFFFFFFF);
        chk("load_busy", busy, 1'b1);
        chk("load_ready", job_ready, 1'b0);
        step();
        chk("j1_start", core_start, 4'b1111);
        chk("j1_rs", core_nonce_start,
            {32'hC0000000, 32'h80000000, 32'h40000000, 32'h00000000});
        chk("j1_re", core_nonce_end,
            {32'hFFFFFFFF, 32'hBFFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF});
        chk("j1_mid", core_midstate, {8{32'hA5A55A5A}});
        chk("j1_data", core_data, {3{32'hFFFFFFFF ^ 32'h3C3CC3C3}});
        step();
        chk("j1_start_pulse", core_start, '0);
        done_pulse(4'b1111);
        chk("j1_exh", exhausted, 1'b1);
        chk("j1_busy_exh", busy, 1'b1);
        step();
        chk("j1_busy_end", busy, 1'b0);
        chk("j1_exh_end", exhausted, 1'b0);

        // Remainder absorbed by the last core
        push_job(32'h1DAC2B00, 32'h1DAC2B0A);
        step();
        chk("j2_start", core_start, 4'b1111);
        chk("j2_rs", core_nonce_start,
            {32'h1DAC2B06, 32'h1DAC2B04, 32'h1DAC2B02, 32'h1DAC2B00});
        chk("j2_re", core_nonce_end,
            {32'h1DAC2B0A, 32'h1DAC2B05, 32'h1DAC2B03, 32'h1DAC2B01});
        done_pulse(4'b0101);
        chk("j2_exh_partial", exhausted, 1'b0);
        done_pulse(4'b1010);
        chk("j2_exh", exhausted, 1'b1);
        step();
        chk("j2_busy_end", busy, 1'b0);

        // Span smaller than core count: core 0 only
        push_job(32'h10, 32'h12);
        step();
        chk("j3_start", core_start, 4'b0001);
        chk("j3_rs0", core_nonce_start[31:0], 32'h10);
        chk("j3_re0", core_nonce_end[31:0], 32'h12);
        done_pulse(4'b0010);
        chk("j3_exh_unstarted", exhausted, 1'b0);
        done_pulse(4'b0001);
        chk("j3_exh", exhausted, 1'b1);
        step();
        chk("j3_busy_end", busy, 1'b0);

        // Empty job
        push_job(32'h5, 32'h4);
        chk("j4_busy", busy, 1'b1);
        step();
        chk("j4_exh", exhausted, 1'b1);
        chk("j4_start", core_start, '0);
        step();
        chk("j4_busy_end", busy, 1'b0);
        chk("j4_exh_end", exhausted, 1'b0);

        // Found path with a stalled consumer
        push_job(32'h0, 32'h0000FFFF);
        step();
        chk("j5_start", core_start, 4'b1111);
        nonce_ready = 1'b0;
        core_found = 4'b1101;
        core_nonce = {32'hCCCC0003, 32'hBBBB0002, 32'h0, 32'hAAAA0000};
        sb.push_back(32'hAAAA0000);
        sb.push_back(32'hBBBB0002);
        sb.push_back(32'hCCCC0003);
        step();
        core_found = '0;
        repeat (4) step();
        chk("j5_valid", nonce_valid, 1'b1);
        chk("j5_head", nonce_out, 32'hAAAA0000);
        core_found = 4'b0010;
        core_nonce[63:32] = 32'h11110001;
        sb.push_back(32'h11110001);
        step();
        core_nonce[63:32] = 32'h22220001;
        step();
        core_found = 4'b0001;
        core_nonce[31:0] = 32'hDDDD0000;
        sb.push_back(32'hDDDD0000);
        step();
        core_found = '0;
        repeat (3) step();
        chk("j5_dropped", dropped_count, 8'd1);
        chk("j5_head_hold", nonce_out, 32'hAAAA0000);
        nonce_ready = 1'b1;
        repeat (7) step();
        chk("j5_pops", n_pops, 5);
        chk("j5_drained", nonce_valid, 1'b0);
        chk("j5_sb_empty", sb.size(), 0);

        // Preempt with a pending nonce in flight
        nonce_ready = 1'b0;
        core_found = 4'b0100;
        core_nonce[95:64] = 32'hEEEE0002;
        step();
        core_found = '0;
        repeat (2) step();
        chk("j6_pre_valid", nonce_valid, 1'b1);
        push_job(32'h1DAC2B00, 32'hFFFFFFFF);
        chk("j6_flush", nonce_valid, 1'b0);
        chk("j6_busy", busy, 1'b1);
        step();
        chk("j6_start", core_start, 4'b1111);
        chk("j6_rs0", core_nonce_start[31:0], 32'h1DAC2B00);
        chk("j6_re0", core_nonce_end[31:0], 32'h5641203F);
        chk("j6_re3", core_nonce_end[127:96], 32'hFFFFFFFF);
        chk("j6_still_empty", nonce_valid, 1'b0);
        nonce_ready = 1'b1;
        core_found = 4'b0001;
        core_nonce[31:0] = 32'h1DAC2B7C;
        sb.push_back(32'h1DAC2B7C);
        step();
        core_found = '0;
        chk("j6_lat1", nonce_valid, 1'b0);
        step();
        chk("j6_lat2", nonce_valid, 1'b1);
        chk("j6_nonce", nonce_out, 32'h1DAC2B7C);
        step();
        chk("j6_popped", nonce_valid, 1'b0);
        done_pulse(4'b1111);
        chk("j6_exh", exhausted, 1'b1);
        step();
        chk("j6_busy_end", busy, 1'b0);
        chk("final_sb_empty", sb.size(), 0);
        chk("final_dropped", dropped_count, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/job_dispatcher.md
# job_dispatcher

Job scheduler between the UART command decoder (PUSH_JOB) and an array of hashing cores. It splits an accepted job's nonce range `[nonce_min, nonce_max]` into per-core sub-ranges and starts the cores. It collects golden nonces from all cores through round-robin arbitration into a small FIFO feeding the MSG_NONCE transmitter, and reports when the job's range is exhausted.

## Interface
- `NUM_CORES`, 4: number of hashing cores; power of two, 1..16.
- `LOG2_CORES`, 2: log2(`NUM_CORES`).
- `FIFO_DEPTH`, 4: found-nonce FIFO entries; power of two.

Ports:
- `CLK`  in  1  system clock; all logic on rising edge.
- `RST_N`  in  1  synchronous active-low reset.
- `job_valid`  in  1  job offered.
- `job_ready`  out  1  job accepted when `job_valid & job_ready`.
- `job_midstate`  in  256  midstate hash.
- `job_data`  in  96  merkle tail, time, bits.
- `job_nonce_min`  in  32  first nonce, inclusive.
- `job_nonce_max`  in  32  last nonce, inclusive.
- `core_start`  out  NUM_CORES  one-cycle start/restart pulse per core.
- `core_midstate`  out  256  broadcast midstate, registered.
- `core_data`  out  96  broadcast data, registered.
- `core_nonce_start`  out  32*NUM_CORES  per-core first nonce; core i in bits [32i+31:32i].
- `core_nonce_end`  out  32*NUM_CORES  per-core last nonce.
- `core_done`  in  NUM_CORES  pulse: core finished its range.
- `core_found`  in  NUM_CORES  pulse: golden nonce on `core_nonce`.
- `core_nonce`  in  32*NUM_CORES  found nonce, valid with `core_found`.
- `nonce_valid`  out  1  FIFO head valid.
- `nonce_ready`  in  1  consumer pops on `nonce_valid & nonce_ready`.
- `nonce_out`  out  32  FIFO head.
- `busy`  out  1  state != IDLE.
- `exhausted`  out  1  one-cycle pulse: all started cores done.
- `dropped_count`  out  8  saturating count of lost nonces.

## Operation
- States: IDLE, LOAD, RUN.
- IDLE: `job_ready`=1. On accept: register midstate, data, min, max; flush FIFO, pending flags and done mask; go to LOAD.
- RUN: `job_ready`=1. A new accept preempts the job: the same flush applies, go to LOAD. Old cores are restarted by the next `core_start`.
- LOAD: `job_ready`=0.
  - span = max − min + 1, 33-bit, so 0..FFFFFFFF gives 2^32. chunk = span >> LOG2_CORES.
  - min > max: empty job. `core_start`=0, pulse `exhausted`, go to IDLE.
  - chunk = 0: core 0 gets [min, max]; only bit 0 of started mask is set.
  - Otherwise core i gets start = min + i·chunk, end = start + chunk − 1. The last core's end = max and absorbs the remainder. All started-mask bits are set.
  - Pulse `core_start` = started mask, go to RUN.
- Range and broadcast outputs hold until the next LOAD.
- Done tracking: `core_done[i]` sets `done_mask[i]` only if started. `done_mask` ⊇ started mask → pulse `exhausted`, go to IDLE. The FIFO keeps draining; it is not flushed.
- Found path:
  - `core_found[i]` sets `pending[i]` and latches the nonce.
  - If `pending[i]` is already set, the new nonce is discarded and `dropped_count` increments, saturating at 255.
  - Each cycle with FIFO not full, round-robin picks the lowest pending index ≥ `rr_ptr` (wrapping), writes it to the FIFO, clears its pending flag, and sets `rr_ptr` = index+1.
  - One write per cycle. Push and pop in the same cycle are allowed when the FIFO is full.
  - Found pulses during the LOAD cycle or in IDLE are ignored.
- Reset: state IDLE, `job_ready`=1, every other output 0, `rr_ptr`=0, FIFO empty, `dropped_count`=0.

## Timing
- Accept at edge T → LOAD during T+1 → `core_start` and valid ranges at T+2, `busy`=1 from T+1.
- Empty job: `exhausted` at T+2, `busy`=0 at T+3.
- `core_found` at C (FIFO empty, no other pending) → `nonce_valid` at C+2.
- Last `core_done` at D → `exhausted` at D+1, `busy`=0 at D+2.
- Preempt at T: `nonce_valid`=0 from T+1.

## Test plan
- Reset with `RST_N`=0 for 2 cycles → `job_ready`=1 and all other outputs 0. `busy` stays 0 with idle inputs.
- Job min 0, max FFFFFFFF, `NUM_CORES`=4 → ranges [0,3FFFFFFF] [40000000,7FFFFFFF] [80000000,BFFFFFFF] [C0000000,FFFFFFFF], `core_start`=1111 at T+2.
- Job min 1DAC2B00, max 1DAC2B0A → ranges [..00,..01] [..02,..03] [..04,..05] [..06,..0A].
- Job min 10, max 12 → core 0 only gets [10,12], `core_start`=0001. Job min 5, max 4 → `exhausted` at T+2, `core_start` stays 0.
- With `nonce_ready`=0:
  - Cores 0, 2, 3 found in the same cycle (nonces A, B, C) → FIFO order A, B, C.
  - Then core 1 found twice, then core 0 → FIFO full (4), core 0 held pending; the second core 1 find increments `dropped_count` to 1.
  - Release `nonce_ready` → 5 pops, in order.
- Pending nonces during RUN, then new job (min 1DAC2B00, max FFFFFFFF) → `nonce_valid`=0 at T+1 and restart at T+2. Core 0 reports 1DAC2B7C → `nonce_out`=1DAC2B7C. All `core_done` → `exhausted` pulse.
